// File: rtl/power_switch_emu_pkg.sv
// Shared types and sizing helper for the power-switch emulator.
package power_switch_emu_pkg;

    typedef enum logic [1:0] {
        PWR_ON,
        PWR_RAMP_DOWN,
        PWR_OFF,
        PWR_RAMP_UP
    } pwr_state_e;

    // Wide enough to hold the larger latency minus one.
    function automatic int cnt_width(input int on_lat, input int off_lat);
        int max_lat;
        max_lat = (on_lat > off_lat) ? on_lat : off_lat;
        return $clog2(max_lat) + 1;
    endfunction

endpackage

// File: rtl/power_switch_emu_domain.sv
// One power domain: ramp FSM, ramp counter and sticky isolation-error flag.
module power_switch_emu_domain
    import power_switch_emu_pkg::*;
#(
    parameter int ON_LATENCY  = 16,
    parameter int OFF_LATENCY = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic switch_n_i,
    input  logic iso_n_i,
    input  logic err_clr_i,
    output logic switch_ack_n_o,
    output logic busy_o,
    output logic iso_err_o
);

    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_set;
    logic             ack_n_q, busy_q, iso_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            PWR_ON: begin
                if (switch_n_i) begin
                    state_d = PWR_RAMP_DOWN;
                    cnt_d   = OFF_LOAD;
                    err_set = iso_n_i;
                end
            end
            PWR_RAMP_DOWN: begin
                if (!switch_n_i)        state_d = PWR_ON;
                else if (cnt_q == '0)   state_d = PWR_OFF;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            PWR_OFF: begin
                if (!switch_n_i) begin
                    state_d = PWR_RAMP_UP;
                    cnt_d   = ON_LOAD;
                end
            end
            PWR_RAMP_UP: begin
                if (switch_n_i)         state_d = PWR_OFF;
                else if (cnt_q == '0)   state_d = PWR_ON;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = PWR_ON;
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PWR_ON;
            cnt_q     <= '0;
            ack_n_q   <= 1'b0;
            busy_q    <= 1'b0;
            iso_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_n_q   <= (state_d == PWR_OFF) || (state_d == PWR_RAMP_UP);
            busy_q    <= (state_d == PWR_RAMP_DOWN) || (state_d == PWR_RAMP_UP);
            iso_err_q <= err_set | (iso_err_q & ~err_clr_i);
        end
    end

    assign switch_ack_n_o = ack_n_q;
    assign busy_o         = busy_q;
    assign iso_err_o      = iso_err_q;

endmodule

// File: rtl/power_switch_emu.sv
// Behavioural power-switch emulator: fans the request buses out to one
// independent ramp FSM per power domain.
module power_switch_emu
    import power_switch_emu_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int ON_LATENCY  = 16,
    parameter int OFF_LATENCY = 16,
    parameter int CNT_W       = cnt_width(ON_LATENCY, OFF_LATENCY)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] switch_n_i,
    input  logic [NUM_DOMAINS-1:0] iso_n_i,
    input  logic                   err_clr_i,
    output logic [NUM_DOMAINS-1:0] switch_ack_n_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] iso_err_o
);

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_domain
        power_switch_emu_domain #(
            .ON_LATENCY  (ON_LATENCY),
            .OFF_LATENCY (OFF_LATENCY),
            .CNT_W       (CNT_W)
        ) u_domain (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .switch_n_i     (switch_n_i[d]),
            .iso_n_i        (iso_n_i[d]),
            .err_clr_i      (err_clr_i),
            .switch_ack_n_o (switch_ack_n_o[d]),
            .busy_o         (busy_o[d]),
            .iso_err_o      (iso_err_o[d])
        );
    end

endmodule

// File: tb/tb_power_switch_emu.sv
// Bench for power_switch_emu: a 16-cycle build and a 1-cycle build driven by
// the same inputs, both compared against a run-length reference model.
module tb_power_switch_emu;

    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] sw;
    logic [ND-1:0] iso;
    logic          clr;
    logic [ND-1:0] ack, busy, err;
    logic [ND-1:0] ack_f, busy_f, err_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    power_switch_emu #(.NUM_DOMAINS(ND), .ON_LATENCY(16), .OFF_LATENCY(16)) dut (
        .clk_i(clk), .rst_i(rst), .switch_n_i(sw), .iso_n_i(iso), .err_clr_i(clr),
        .switch_ack_n_o(ack), .busy_o(busy), .iso_err_o(err)
    );

    power_switch_emu #(.NUM_DOMAINS(ND), .ON_LATENCY(1), .OFF_LATENCY(1)) dut_fast (
        .clk_i(clk), .rst_i(rst), .switch_n_i(sw), .iso_n_i(iso), .err_clr_i(clr),
        .switch_ack_n_o(ack_f), .busy_o(busy_f), .iso_err_o(err_f)
    );

    // Reference: ack follows the request once the request has differed from
    // ack for latency+1 consecutive sampling edges; busy while that run is open.
    int            lat[2] = '{16, 1};
    logic [ND-1:0] m_ack[2];
    logic [ND-1:0] m_err[2];
    int            m_run[2][ND];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = '0;
            m_err[k] = '0;
            for (int d = 0; d < ND; d++) m_run[k][d] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < ND; d++) begin
                if (rst) begin
                    m_ack[k][d] = 1'b0;
                    m_err[k][d] = 1'b0;
                    m_run[k][d] = 0;
                end else begin
                    if (!m_ack[k][d] && m_run[k][d] == 0 && sw[d] && iso[d])
                        m_err[k][d] = 1'b1;
                    else if (clr)
                        m_err[k][d] = 1'b0;
                    if (sw[d] != m_ack[k][d]) begin
                        m_run[k][d] = m_run[k][d] + 1;
                        if (m_run[k][d] == lat[k] + 1) begin
                            m_ack[k][d] = sw[d];
                            m_run[k][d] = 0;
                        end
                    end else begin
                        m_run[k][d] = 0;
                    end
                end
            end
        end
    end

    function automatic logic [ND-1:0] exp_busy(input int k);
        logic [ND-1:0] b;
        for (int d = 0; d < ND; d++) b[d] = (m_run[k][d] != 0);
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1; sw = '0; iso = '0; clr = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ack, busy, err, ack_f, busy_f, err_f} !== 18'b0) begin
            $display("FAIL reset_state: got %b required 0",
                     {ack, busy, err, ack_f, busy_f, err_f});
            bad++;
        end
        @(negedge clk);
        total++;
        if ({ack, busy, err} !== {m_ack[0], exp_busy(0), m_err[0]}) begin
            $display("FAIL reset_idle: got %b required %b",
                     {ack, busy, err}, {m_ack[0], exp_busy(0), m_err[0]});
            bad++;
        end
    endtask

    task automatic test_power_off();
        iso[0] = 1'b0;
        sw[0]  = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            total++;
            if (ack[0] !== (i >= 17) || busy[0] !== (i >= 1 && i <= 16) || err !== 3'b0) begin
                $display("FAIL power_off edge %0d: ack=%b busy=%b err=%b required ack=%b busy=%b err=000",
                         i, ack[0], busy[0], err, (i >= 17), (i <= 16));
                bad++;
            end
            total++;
            if (ack_f[0] !== (i >= 2) || busy_f[0] !== (i == 1)) begin
                $display("FAIL power_off_lat1 edge %0d: ack=%b busy=%b required ack=%b busy=%b",
                         i, ack_f[0], busy_f[0], (i >= 2), (i == 1));
                bad++;
            end
        end
    endtask

    task automatic test_power_on();
        sw[0] = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            total++;
            if (ack[0] !== (i < 17) || busy[0] !== (i <= 16) || ack[2:1] !== 2'b00 || busy[2:1] !== 2'b00) begin
                $display("FAIL power_on edge %0d: ack=%b busy=%b required ack0=%b busy0=%b others 0",
                         i, ack, busy, (i < 17), (i <= 16));
                bad++;
            end
            total++;
            if (ack_f[0] !== (i < 2) || busy_f[0] !== (i == 1)) begin
                $display("FAIL power_on_lat1 edge %0d: ack=%b busy=%b required ack=%b busy=%b",
                         i, ack_f[0], busy_f[0], (i < 2), (i == 1));
                bad++;
            end
        end
    endtask

    task automatic test_abort();
        sw[0] = 1'b1;
        repeat (9) @(negedge clk);
        sw[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
            $display("FAIL abort: ack=%b busy=%b required ack=0 busy=0", ack[0], busy[0]);
            bad++;
        end
        sw[0] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            total++;
            if (ack[0] !== (i >= 17) ||
                {ack, busy, err, ack_f, busy_f, err_f} !==
                {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]}) begin
                $display("FAIL rerequest edge %0d: got %b required %b", i,
                         {ack, busy, err, ack_f, busy_f, err_f},
                         {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]});
                bad++;
            end
        end
        sw[0] = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_iso_err();
        iso[1] = 1'b1;
        sw[1]  = 1'b1;
        @(negedge clk);
        total++;
        if (err[1] !== 1'b1 || err_f[1] !== 1'b1) begin
            $display("FAIL iso_err_set: err=%b err_f=%b required 1", err[1], err_f[1]);
            bad++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (err[1] !== 1'b1) begin
            $display("FAIL iso_err_sticky: err=%b required 1", err[1]);
            bad++;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (err[1] !== 1'b0 || err_f[1] !== 1'b0) begin
            $display("FAIL iso_err_clear: err=%b err_f=%b required 0", err[1], err_f[1]);
            bad++;
        end
        sw[1] = 1'b0;
        @(negedge clk);
        total++;
        if (busy[1] !== 1'b0 || ack[1] !== 1'b0) begin
            $display("FAIL iso_abort: busy=%b ack=%b required 0 0", busy[1], ack[1]);
            bad++;
        end
        sw[1] = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (err[1] !== 1'b1) begin
            $display("FAIL iso_set_beats_clear: err=%b required 1", err[1]);
            bad++;
        end
        sw[1] = 1'b0;
        iso   = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if ({ack, busy, err, ack_f, busy_f, err_f} !==
            {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]}) begin
            $display("FAIL iso_settle: got %b required %b",
                     {ack, busy, err, ack_f, busy_f, err_f},
                     {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]});
            bad++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_ramp();
        iso = '0;
        sw  = 3'b111;
        repeat (11) @(negedge clk);
        total++;
        if (busy !== 3'b111 || ack !== 3'b000) begin
            $display("FAIL mid_ramp_pre: busy=%b ack=%b required 111 000", busy, ack);
            bad++;
        end
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        total++;
        if ({ack, busy, err, ack_f, busy_f, err_f} !== 18'b0) begin
            $display("FAIL mid_ramp_reset: got %b required 0",
                     {ack, busy, err, ack_f, busy_f, err_f});
            bad++;
        end
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            total++;
            if (ack !== ((i >= 17) ? 3'b111 : 3'b000)) begin
                $display("FAIL post_reset_ramp edge %0d: ack=%b required %b", i, ack,
                         (i >= 17) ? 3'b111 : 3'b000);
                bad++;
            end
        end
        sw = '0;
        repeat (18) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 19) == 0) sw[d] = ~sw[d];
            iso = ND'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            total++;
            if ({ack, busy, err, ack_f, busy_f, err_f} !==
                {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]}) begin
                $display("FAIL random cycle %0d: got %b required %b", c,
                         {ack, busy, err, ack_f, busy_f, err_f},
                         {m_ack[0], exp_busy(0), m_err[0], m_ack[1], exp_busy(1), m_err[1]});
                bad++;
            end
        end
        rst = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_off();
        test_power_on();
        test_abort();
        test_iso_err();
        test_reset_mid_ramp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/power_switch_emu.md
# power_switch_emu

Behavioural power-switch model for the simulation testbench: consumes the per-domain `*_powergate_switch_n` requests driven by `gr_heep_top` (CPU, peripheral and external domains) and produces the matching `*_powergate_switch_ack_n` responses after a programmable ramp latency. It replaces the plain flop delay line with a per-domain state machine that:
- handles request reversal mid-ramp;
- flags power-off requests issued without prior isolation.

## Interface
Parameters:
- `NUM_DOMAINS`, 3: number of independent power domains (≥1).
- `ON_LATENCY`, 16: cycles from sampled power-on request to `ack_n` falling (≥1).
- `OFF_LATENCY`, 16: cycles from sampled power-off request to `ack_n` rising (≥1).
- `CNT_W`, `$clog2(max(ON_LATENCY,OFF_LATENCY))+1`: ramp counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `switch_n_i`  in  NUM_DOMAINS  switch request per domain; 0 = power on, 1 = power off.
- `iso_n_i`  in  NUM_DOMAINS  isolation per domain; 0 = isolated.
- `err_clr_i`  in  1  clears all `iso_err_o` bits.
- `switch_ack_n_o`  out  NUM_DOMAINS  switch acknowledge; 0 = powered, 1 = off.
- `busy_o`  out  NUM_DOMAINS  domain is mid-ramp.
- `iso_err_o`  out  NUM_DOMAINS  sticky flag: power-off started while not isolated.

## Operation
- Each domain runs an independent FSM with states ON, RAMP_DOWN, OFF and RAMP_UP, plus a down-counter `cnt`.
- Reset state for every domain is ON, `cnt = 0`.
- Output reset values: `switch_ack_n_o = 0`, `busy_o = 0`, `iso_err_o = 0`.

Transitions, evaluated at each rising edge:
- ON:
  - `switch_n_i = 1` → RAMP_DOWN, load `cnt = OFF_LATENCY-1`.
  - If `iso_n_i = 1` on that same edge, set `iso_err_o[d]`.
- RAMP_DOWN:
  - `switch_n_i = 0` → ON (abort; ack never toggled).
  - Otherwise, `cnt = 0` → OFF.
  - Otherwise, decrement `cnt`.
- OFF:
  - `switch_n_i = 0` → RAMP_UP, load `cnt = ON_LATENCY-1`.
- RAMP_UP:
  - `switch_n_i = 1` → OFF (abort).
  - Otherwise, `cnt = 0` → ON.
  - Otherwise, decrement `cnt`.

Output decode, registered from the next state:
- `switch_ack_n_o[d] = 1` in OFF and RAMP_UP, 0 in ON and RAMP_DOWN.
- `busy_o[d] = 1` in RAMP_DOWN and RAMP_UP.

`iso_err_o` rules:
- Sticky; cleared only by `rst_i` or `err_clr_i`.
- If a clear and a set coincide on the same edge, set wins.
- An abort followed by a new ramp-down re-checks `iso_n_i`.

Domains are fully independent; simultaneous requests on several domains proceed in parallel.

## Timing
- Sampling edge E0 = first edge at which the FSM sees the new `switch_n_i` level.
- Power-off: `switch_ack_n_o` goes high at edge E0+OFF_LATENCY and is visible in the following cycle. `busy_o` is high from after E0 until that edge.
- Power-on: symmetric, with ON_LATENCY.
- `switch_n_i` is used unsynchronised (same clock domain as `gr_heep_top`).
- Glitch of one cycle during a ramp:
  - The ramp aborts and a fresh ramp starts on the next sampling edge, with a full reload.
  - A one-cycle pulse of `switch_n_i` while in ON enters RAMP_DOWN, then returns to ON on the next edge; `ack_n` stays 0.
- Reset mid-ramp: all domains return to ON on the reset edge; outputs take reset values in the following cycle. Reset overrides `err_clr_i` and every request.
- `OFF_LATENCY = 1`: ack changes at E0+1, with `busy_o` high for exactly one cycle.

## Structure
- `power_switch_emu_pkg`: `pwr_state_e` enum {PWR_ON, PWR_RAMP_DOWN, PWR_OFF, PWR_RAMP_UP}; a `CNT_W` helper function.
- Sub-module `power_switch_emu_domain`: one FSM, counter and error flag, instantiated `NUM_DOMAINS` times via generate.
- Top level only fans out the buses and `err_clr_i`.

## Test plan
- Reset, then `switch_n_i[0]` 0→1 with `iso_n_i[0] = 0`, OFF_LATENCY=16 → `ack_n[0]` rises exactly 16 edges after E0. `busy_o[0]` is high for 16 cycles. `iso_err_o = 0`.
- From OFF, `switch_n_i[0]` → 0, ON_LATENCY=16 → `ack_n[0]` falls 16 edges after E0. Other domains are unchanged.
- RAMP_DOWN aborted at cnt=7 by `switch_n_i` → 0 → ack stays 0, `busy_o` drops next cycle. Re-request → full 16-cycle ramp.
- Power-off with `iso_n_i[1] = 1` → `iso_err_o[1] = 1` and stays set. `err_clr_i` pulse → 0. Clear coinciding with a new violation → remains 1.
- All three domains switched off on the same edge, with `rst_i` asserted at cnt=5 → all outputs 0 the cycle after the reset edge, FSMs in ON.
- OFF_LATENCY=ON_LATENCY=1 build: full off/on sequence → each ack transitions one edge after E0.
